// File: rtl/rle_pkg.sv
// Shared defaults, FSM encoding and pair record for the run-length
// sequencing controller.
package rle_pkg;

    localparam int DEF_DATA_W    = 13;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_MAX_RUN   = 255;
    localparam int DEF_BLOCK_LEN = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rle_state_e;

    typedef struct packed {
        logic signed [DEF_DATA_W-1:0] value;
        logic [DEF_CNT_W-1:0]         count;
        logic                         last;
    } rle_pair_t;

    // Width of an index spanning 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rle_pair_slot.sv
// One-entry output register with valid/ready; it can be reloaded on the
// same edge its current contents are taken, so a full-rate stream has no bubble.
module rle_pair_slot #(
    parameter int W = 22
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         free
);

    assign free = !valid || ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load && free) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rle_seq_ctrl.sv
// Run-length sequencing controller: tracks the current run and emits
// (value, count, last) pairs, splitting runs at MAX_RUN and at every block end.
module rle_seq_ctrl
    import rle_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_RUN   = DEF_MAX_RUN,
    parameter int BLOCK_LEN = DEF_BLOCK_LEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_value,
    output logic [CNT_W-1:0]         out_count,
    output logic                     out_last,
    output logic                     blk_done
);

    localparam int IDX_W = idx_width(BLOCK_LEN);

    typedef struct packed {
        logic signed [DATA_W-1:0] value;
        logic [CNT_W-1:0]         count;
        logic                     last;
    } pair_t;

    localparam int PAIR_W = $bits(pair_t);

    rle_state_e               state;
    logic [IDX_W-1:0]         idx;
    logic signed [DATA_W-1:0] cur_val;
    logic [CNT_W-1:0]         cur_cnt;
    logic                     run_active;
    pair_t                    pend;
    logic                     pend_valid;

    logic                     slot_free;
    logic                     accept;
    logic                     blk_end;
    logic                     emit_mid;
    logic signed [DATA_W-1:0] nxt_val;
    logic [CNT_W-1:0]         nxt_cnt;
    pair_t                    mid_pair;
    pair_t                    end_pair;
    pair_t                    load_pair;
    logic                     load;
    pair_t                    slot_q;

    // Never depends on in_valid, so upstream may wait on in_ready safely.
    assign in_ready = !pend_valid && slot_free;
    assign accept   = in_valid && in_ready;
    assign blk_end  = (idx == IDX_W'(BLOCK_LEN - 1));

    always_comb begin
        emit_mid = 1'b0;
        nxt_val  = in_data;
        nxt_cnt  = CNT_W'(1);
        if (run_active) begin
            if ((in_data == cur_val) && (cur_cnt < CNT_W'(MAX_RUN))) begin
                nxt_val = cur_val;
                nxt_cnt = cur_cnt + 1'b1;
            end else begin
                emit_mid = 1'b1;
            end
        end
        mid_pair.value = cur_val;
        mid_pair.count = cur_cnt;
        mid_pair.last  = 1'b0;
        end_pair.value = nxt_val;
        end_pair.count = nxt_cnt;
        end_pair.last  = 1'b1;
    end

    // A mid-block pair takes the slot first; a block-end pair produced by the
    // same accept waits one cycle in the pending register.
    always_comb begin
        load      = 1'b0;
        load_pair = pend;
        if (accept) begin
            if (emit_mid) begin
                load      = 1'b1;
                load_pair = mid_pair;
            end else if (blk_end) begin
                load      = 1'b1;
                load_pair = end_pair;
            end
        end else if ((state == DRAIN) && slot_free) begin
            load      = 1'b1;
            load_pair = pend;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cur_val    <= '0;
            cur_cnt    <= '0;
            run_active <= 1'b0;
            pend       <= '0;
            pend_valid <= 1'b0;
            blk_done   <= 1'b0;
        end else begin
            blk_done <= out_valid && out_ready && out_last;
            if (accept) begin
                idx        <= blk_end ? '0 : idx + 1'b1;
                cur_val    <= nxt_val;
                cur_cnt    <= nxt_cnt;
                run_active <= !blk_end;
                if (emit_mid && blk_end) begin
                    pend       <= end_pair;
                    pend_valid <= 1'b1;
                    state      <= DRAIN;
                end else begin
                    state <= blk_end ? IDLE : RUN;
                end
            end else if ((state == DRAIN) && slot_free) begin
                pend_valid <= 1'b0;
                state      <= IDLE;
            end
        end
    end

    rle_pair_slot #(
        .W(PAIR_W)
    ) u_out_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_data(load_pair),
        .ready    (out_ready),
        .valid    (out_valid),
        .data     (slot_q),
        .free     (slot_free)
    );

    assign out_value = slot_q.value;
    assign out_count = slot_q.count;
    assign out_last  = slot_q.last;

endmodule

// File: tb/tb_rle_seq_ctrl.sv
// Bench for rle_seq_ctrl: a short-block instance (8) and a long-block
// instance (512), checked against a block/run chunking reference model.
module tb_rle_seq_ctrl;
    import rle_pkg::*;

    localparam int DW   = DEF_DATA_W;
    localparam int CW   = DEF_CNT_W;
    localparam int PW   = DW + CW + 1;
    localparam int MAXR = 255;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [1:0]           in_valid;
    logic [1:0]           in_ready;
    logic [1:0][DW-1:0]   in_data;
    logic [1:0]           out_valid;
    logic [1:0]           out_ready;
    logic [1:0][DW-1:0]   out_value;
    logic [1:0][CW-1:0]   out_count;
    logic [1:0]           out_last;
    logic [1:0]           blk_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    bit mon_on = 1'b0;
    bit win_on = 1'b0;
    int win_d = 0;
    int low_cnt = 0;
    int bd_cnt = 0;

    logic signed [DW-1:0] acc_q[$];
    logic [PW-1:0]        obs_q[$];
    int                   obs_t_q[$];
    logic [PW-1:0]        exp_q[$];

    logic [PW-1:0] hold_p [2];
    bit            hold_v [2];
    bit            exp_bd [2];
    logic [PW-1:0] cur_p;

    rle_seq_ctrl #(.BLOCK_LEN(8)) u_dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_value(out_value[0]),
        .out_count(out_count[0]), .out_last(out_last[0]), .blk_done(blk_done[0])
    );

    rle_seq_ctrl #(.BLOCK_LEN(512)) u_dut_l (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_value(out_value[1]),
        .out_count(out_count[1]), .out_last(out_last[1]), .blk_done(blk_done[1])
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pk(input logic [DW-1:0] v, input logic [CW-1:0] c, input logic l);
        return {v, c, l};
    endfunction

    function automatic logic signed [DW-1:0] rand_coef(input logic signed [DW-1:0] prev);
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 5) return prev;
        if (r == 9) return ($urandom_range(0, 1) != 0) ? 13'h0fff : 13'h1000;
        return DW'(int'($urandom_range(0, 6)) - 3);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one coefficient and hold it until the edge that accepts it.
    task automatic send(input int d, input logic signed [DW-1:0] v);
        int budget;
        budget = 0;
        in_valid[d] = 1'b1;
        in_data[d]  = v;
        forever begin
            @(negedge clk);
            if (rst_n && in_ready[d]) break;
            budget++;
            if (budget > 200) begin
                check_eq("send_timeout", 32'(budget), 32'(0));
                break;
            end
        end
        step();
        in_valid[d] = 1'b0;
    endtask

    task automatic phase_start(input int d);
        acc_q.delete();
        obs_q.delete();
        obs_t_q.delete();
        low_cnt = 0;
        bd_cnt  = 0;
        win_d   = d;
        win_on  = 1'b1;
    endtask

    // Reference: cut the accepted samples into blocks, each block into
    // maximal equal-value runs, each run into MAX_RUN-sized chunks.
    task automatic phase_end(input int d, input string tag, input int nsent);
        int bl, nblk, j, k, len, sum, nlast;
        logic signed [DW-1:0] v;
        repeat (8) step();
        win_on = 1'b0;
        bl = (d == 0) ? 8 : 512;
        exp_q.delete();
        nblk = acc_q.size() / bl;
        for (int b = 0; b < nblk; b++) begin
            j = b * bl;
            while (j < (b + 1) * bl) begin
                v = acc_q[j];
                k = j;
                while (k < (b + 1) * bl && acc_q[k] == v) k++;
                len = k - j;
                while (len > MAXR) begin
                    exp_q.push_back(pk(v, CW'(MAXR), 1'b0));
                    len -= MAXR;
                end
                exp_q.push_back(pk(v, CW'(len), k == (b + 1) * bl));
                j = k;
            end
        end
        check_eq({tag, "_accepted"}, 32'(acc_q.size()), 32'(nsent));
        check_eq({tag, "_npairs"}, 32'(obs_q.size()), 32'(exp_q.size()));
        sum = 0;
        nlast = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            sum += int'(obs_q[i][CW:1]);
            nlast += int'(obs_q[i][0]);
            if (i < exp_q.size()) check_eq({tag, "_pair"}, 32'(obs_q[i]), 32'(exp_q[i]));
        end
        check_eq({tag, "_decoded_len"}, 32'(sum), 32'(acc_q.size()));
        check_eq({tag, "_last_pairs"}, 32'(nlast), 32'(nblk));
        check_eq({tag, "_blk_done_pulses"}, 32'(bd_cnt), 32'(nblk));
    endtask

    task automatic reset_state(input int d);
        check_eq("rst_out_valid", 32'(out_valid[d]), 32'(0));
        check_eq("rst_out_value", 32'(out_value[d]), 32'(0));
        check_eq("rst_out_count", 32'(out_count[d]), 32'(0));
        check_eq("rst_out_last", 32'(out_last[d]), 32'(0));
        check_eq("rst_blk_done", 32'(blk_done[d]), 32'(0));
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            case (rdy_mode)
                0:       out_ready[d] = 1'b1;
                1:       out_ready[d] = ($urandom_range(0, 3) != 0);
                default: out_ready[d] = 1'b0;
            endcase
        end
    end

    // Monitor: inputs and outputs are stable at the falling edge and show
    // exactly what the next rising edge will do.
    initial forever begin
        @(negedge clk);
        if (mon_on) begin
            for (int d = 0; d < 2; d++) begin
                cur_p = pk(out_value[d], out_count[d], out_last[d]);
                check_eq("blk_done", 32'(blk_done[d]), 32'(exp_bd[d]));
                if (hold_v[d]) check_eq("stall_hold", 32'({out_valid[d], cur_p}), 32'({1'b1, hold_p[d]}));
                if (rst_n && out_valid[d] && !out_ready[d]) check_eq("in_ready_full", 32'(in_ready[d]), 32'(0));
                if (rst_n && out_valid[d] && out_ready[d]) begin
                    obs_q.push_back(cur_p);
                    obs_t_q.push_back(cyc);
                end
                if (rst_n && in_valid[d] && in_ready[d]) acc_q.push_back(in_data[d]);
                if (blk_done[d]) bd_cnt++;
                exp_bd[d] = rst_n && out_valid[d] && out_ready[d] && out_last[d];
                hold_v[d] = rst_n && out_valid[d] && !out_ready[d];
                hold_p[d] = cur_p;
            end
            if (win_on && !in_ready[win_d]) low_cnt++;
        end
    end

    initial begin
        logic signed [DW-1:0] v;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '1;
        hold_v    = '{1'b0, 1'b0};
        exp_bd    = '{1'b0, 1'b0};
        rst_n     = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_state(0);
        reset_state(1);
        step();
        rst_n  = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);
        check_eq("ready_after_reset_s", 32'(in_ready[0]), 32'(1));
        check_eq("ready_after_reset_l", 32'(in_ready[1]), 32'(1));
        step();

        // Three runs inside one short block, no backpressure.
        phase_start(0);
        send(0, 13'sd5); send(0, 13'sd5); send(0, 13'sd5);
        send(0, -13'sd3); send(0, -13'sd3);
        send(0, 13'sd0); send(0, 13'sd0); send(0, 13'sd0);
        phase_end(0, "basic", 8);
        check_eq("basic_in_ready_low", 32'(low_cnt), 32'(0));

        // Value change on the final sample: two pairs from one accept.
        phase_start(0);
        for (int i = 0; i < 7; i++) send(0, 13'sd1);
        send(0, 13'sd2);
        repeat (4) step();
        if (obs_t_q.size() >= 2) check_eq("split_consecutive", 32'(obs_t_q[1] - obs_t_q[0]), 32'(1));
        phase_end(0, "split", 8);
        check_eq("split_in_ready_low", 32'(low_cnt), 32'(1));

        // Saturation at MAX_RUN inside a long block.
        phase_start(1);
        for (int i = 0; i < 300; i++) send(1, 13'sd7);
        for (int i = 0; i < 212; i++) send(1, 13'sd9);
        phase_end(1, "saturate", 512);
        check_eq("saturate_npairs_abs", 32'(obs_q.size()), 32'(3));

        // Ten-cycle output stall in the middle of a stream.
        phase_start(0);
        fork
            begin
                v = 13'sd0;
                for (int i = 0; i < 24; i++) begin
                    v = DW'(int'($urandom_range(0, 3)));
                    send(0, v);
                end
            end
            begin
                repeat (6) step();
                low_cnt = 0;
                rdy_mode = 2;
                repeat (10) step();
                check_eq("stall_in_ready_low", 32'(low_cnt > 0), 32'(1));
                rdy_mode = 0;
            end
        join
        phase_end(0, "stall", 24);

        // Random traffic: gaps on the input, random backpressure on the output.
        phase_start(0);
        rdy_mode = 1;
        v = 13'sd0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
            v = rand_coef(v);
            send(0, v);
        end
        rdy_mode = 0;
        phase_end(0, "random", 1000);

        // Reset with a full output slot and a pending block-end pair.
        phase_start(0);
        rdy_mode = 2;
        step();
        for (int i = 0; i < 7; i++) send(0, 13'sd1);
        send(0, 13'sd2);
        step();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_state(0);
        step();
        rst_n = 1'b1;
        rdy_mode = 0;
        acc_q.delete();
        obs_q.delete();
        obs_t_q.delete();
        @(negedge clk);
        check_eq("rst_pend_in_ready", 32'(in_ready[0]), 32'(1));
        repeat (5) step();
        check_eq("rst_no_stale_pair", 32'(obs_q.size()), 32'(0));
        win_on = 1'b0;

        // Reset mid-run, then a fresh block must start at index 0.
        send(0, 13'sd5); send(0, 13'sd5); send(0, 13'sd6);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        phase_start(0);
        send(0, 13'sd6); send(0, 13'sd6);
        for (int i = 0; i < 5; i++) send(0, 13'sd3);
        send(0, -13'sd1);
        phase_end(0, "fresh_block", 8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
